// File: rtl/mavg_sched.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mavg_sched : round-robin scheduled TAPS-point moving average over NCH channels
// Rev 1.0
// ----------------------------------------------------------------------------
module mavg_sched #(
  parameter int NCH  = 4,
  parameter int W    = 4,
  parameter int TAPS = 4,
  parameter int CW   = (NCH > 1) ? $clog2(NCH) : 1,
  parameter int LT   = $clog2(TAPS)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NCH-1:0]     in_valid,
  input  logic [NCH*W-1:0]   in_x,
  output logic [NCH-1:0]     in_ready,
  input  logic [NCH-1:0]     ch_clr,
  output logic               out_valid,
  output logic [W-1:0]       out_y,
  output logic [CW-1:0]      out_ch,
  output logic               out_warm,
  input  logic               out_ready
);

  localparam int FW = $clog2(TAPS + 1);
  localparam int SW = W + LT;

  logic [W-1:0]  r_hist [NCH][TAPS-1];
  logic [FW-1:0] r_fill [NCH];
  logic [CW-1:0] r_ptr;

  logic [NCH-1:0] w_elig;
  logic           w_slot;
  logic           w_gnt_vld;
  logic [CW-1:0]  w_gnt;
  logic [W-1:0]   w_x;
  logic [SW-1:0]  w_sum;
  logic           w_warm;
  logic           w_xfer;

  function automatic logic [CW-1:0] f_rr_idx(input logic [CW-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= NCH) s = s - NCH;
    return CW'(s);
  endfunction

  assign w_elig = in_valid & ~ch_clr;
  assign w_slot = !out_valid || out_ready;

  // Scan from the far end so the channel closest to r_ptr wins.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt     = '0;
    if (w_slot && !reset) begin
      for (int k = NCH - 1; k >= 0; k--) begin
        if (w_elig[f_rr_idx(r_ptr, k)]) begin
          w_gnt_vld = 1'b1;
          w_gnt     = f_rr_idx(r_ptr, k);
        end
      end
    end
  end

  always_comb begin
    in_ready = '0;
    for (int i = 0; i < NCH; i++) begin
      in_ready[i] = w_gnt_vld && (w_gnt == CW'(i));
    end
  end

  assign w_xfer = w_gnt_vld && in_valid[w_gnt];
  assign w_x    = in_x[w_gnt*W +: W];
  assign w_warm = (r_fill[w_gnt] >= FW'(TAPS - 1));

  always_comb begin
    w_sum = SW'(w_x);
    for (int j = 0; j < TAPS - 1; j++) begin
      w_sum = w_sum + SW'(r_hist[w_gnt][j]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_y     <= '0;
      out_ch    <= '0;
      out_warm  <= 1'b0;
      r_ptr     <= '0;
    end else begin
      if (w_xfer) begin
        out_valid <= 1'b1;
        out_y     <= W'(w_sum >> LT);
        out_ch    <= w_gnt;
        out_warm  <= w_warm;
        r_ptr     <= (w_gnt == CW'(NCH - 1)) ? '0 : w_gnt + 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
      always_ff @(posedge clk) begin
        if (reset || ch_clr[gi]) begin
          r_fill[gi] <= '0;
          for (int j = 0; j < TAPS - 1; j++) r_hist[gi][j] <= '0;
        end else if (w_xfer && (w_gnt == CW'(gi))) begin
          r_hist[gi][0] <= w_x;
          for (int j = 1; j < TAPS - 1; j++) r_hist[gi][j] <= r_hist[gi][j-1];
          if (r_fill[gi] != FW'(TAPS)) r_fill[gi] <= r_fill[gi] + 1'b1;
        end
      end
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_mavg_sched.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_mavg_sched : directed self-checking bench for mavg_sched (NCH=4, W=4, TAPS=4)
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_mavg_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  in_valid;
  logic [15:0] in_x;
  logic [3:0]  in_ready;
  logic [3:0]  ch_clr;
  logic        out_valid;
  logic [3:0]  out_y;
  logic [1:0]  out_ch;
  logic        out_warm;
  logic        out_ready;

  int n_checks = 0;
  int n_fail   = 0;

  mavg_sched #(.NCH(4), .W(4), .TAPS(4)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_x(in_x), .in_ready(in_ready), .ch_clr(ch_clr),
    .out_valid(out_valid), .out_y(out_y), .out_ch(out_ch), .out_warm(out_warm),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; in_valid = '0; in_x = '0; ch_clr = '0; out_ready = 1'b1;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    reset = 1'b1; in_valid = 4'hF;
    #1;
    n_checks++;
    if (in_ready !== 4'h0) begin n_fail++; $display("FAIL reset_in_ready: got %h expected 0", in_ready); end
    tick();
    n_checks++;
    if ({out_valid, out_y, out_ch, out_warm} !== 8'h00) begin
      n_fail++; $display("FAIL reset_outputs: got v=%0d y=%0d ch=%0d w=%0d expected all 0", out_valid, out_y, out_ch, out_warm);
    end
    reset = 1'b0; in_valid = '0;
  endtask

  task automatic test_step();
    int ey [12] = '{3, 7, 11, 15, 15, 15, 11, 7, 3, 0, 0, 0};
    int ew [12] = '{0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1};
    do_reset();
    for (int k = 0; k < 12; k++) begin
      in_valid = 4'b0001;
      in_x     = (k < 6) ? 16'h000F : 16'h0000;
      #1;
      n_checks++;
      if (in_ready !== 4'b0001) begin n_fail++; $display("FAIL step_ready[%0d]: got %b expected 0001", k, in_ready); end
      tick();
      n_checks++;
      if (out_valid !== 1'b1 || out_y !== 4'(ey[k]) || out_warm !== 1'(ew[k]) || out_ch !== 2'd0) begin
        n_fail++;
        $display("FAIL step_out[%0d]: got v=%0d y=%0d w=%0d ch=%0d expected v=1 y=%0d w=%0d ch=0",
                 k, out_valid, out_y, out_warm, out_ch, ey[k], ew[k]);
      end
    end
    in_valid = '0;
    tick();
    n_checks++;
    if (out_valid !== 1'b0 || out_y !== 4'd0) begin
      n_fail++; $display("FAIL step_drain: got v=%0d y=%0d expected v=0 y=0", out_valid, out_y);
    end
  endtask

  task automatic test_round_robin();
    int ey [8] = '{0, 1, 2, 3, 0, 2, 4, 6};
    do_reset();
    in_valid = 4'hF;
    in_x     = {4'd12, 4'd8, 4'd4, 4'd0};
    for (int k = 0; k < 8; k++) begin
      #1;
      n_checks++;
      if (in_ready !== 4'(1 << (k % 4))) begin
        n_fail++; $display("FAIL rr_ready[%0d]: got %b expected %b", k, in_ready, 4'(1 << (k % 4)));
      end
      tick();
      n_checks++;
      if (out_valid !== 1'b1 || out_ch !== 2'(k % 4) || out_y !== 4'(ey[k])) begin
        n_fail++;
        $display("FAIL rr_out[%0d]: got v=%0d ch=%0d y=%0d expected v=1 ch=%0d y=%0d",
                 k, out_valid, out_ch, out_y, k % 4, ey[k]);
      end
    end
    in_valid = '0;
  endtask

  task automatic test_backpressure();
    do_reset();
    in_valid = 4'b0001; in_x = 16'h0008;
    tick();
    n_checks++;
    if (out_valid !== 1'b1 || out_y !== 4'd2) begin
      n_fail++; $display("FAIL bp_first: got v=%0d y=%0d expected v=1 y=2", out_valid, out_y);
    end
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_checks++;
      if (in_ready !== 4'h0) begin n_fail++; $display("FAIL bp_ready[%0d]: got %b expected 0000", k, in_ready); end
      tick();
      n_checks++;
      if (out_valid !== 1'b1 || out_y !== 4'd2 || out_ch !== 2'd0) begin
        n_fail++; $display("FAIL bp_hold[%0d]: got v=%0d y=%0d ch=%0d expected v=1 y=2 ch=0", k, out_valid, out_y, out_ch);
      end
    end
    out_ready = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 4'b0001) begin n_fail++; $display("FAIL bp_release_ready: got %b expected 0001", in_ready); end
    tick();
    n_checks++;
    if (out_valid !== 1'b1 || out_y !== 4'd4) begin
      n_fail++; $display("FAIL bp_release_out: got v=%0d y=%0d expected v=1 y=4", out_valid, out_y);
    end
    in_valid = '0;
  endtask

  task automatic test_clear();
    do_reset();
    in_valid = 4'b0010; in_x = 16'h0080;
    for (int k = 0; k < 4; k++) tick();
    n_checks++;
    if (out_y !== 4'd8 || out_warm !== 1'b1 || out_ch !== 2'd1) begin
      n_fail++; $display("FAIL clr_prime: got y=%0d w=%0d ch=%0d expected y=8 w=1 ch=1", out_y, out_warm, out_ch);
    end
    in_valid = 4'b0110; ch_clr = 4'b0010; in_x = 16'h0480;
    #1;
    n_checks++;
    if (in_ready !== 4'b0100) begin n_fail++; $display("FAIL clr_ready: got %b expected 0100", in_ready); end
    tick();
    n_checks++;
    if (out_valid !== 1'b1 || out_ch !== 2'd2 || out_y !== 4'd1) begin
      n_fail++; $display("FAIL clr_other: got v=%0d ch=%0d y=%0d expected v=1 ch=2 y=1", out_valid, out_ch, out_y);
    end
    ch_clr = '0; in_valid = 4'b0010;
    #1;
    n_checks++;
    if (in_ready !== 4'b0010) begin n_fail++; $display("FAIL clr_after_ready: got %b expected 0010", in_ready); end
    tick();
    n_checks++;
    if (out_ch !== 2'd1 || out_y !== 4'd2 || out_warm !== 1'b0) begin
      n_fail++; $display("FAIL clr_after_out: got ch=%0d y=%0d w=%0d expected ch=1 y=2 w=0", out_ch, out_y, out_warm);
    end
    in_valid = '0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    in_valid = 4'b0001; in_x = 16'h000F;
    for (int k = 0; k < 4; k++) tick();
    reset = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 4'h0) begin n_fail++; $display("FAIL rmid_ready: got %b expected 0000", in_ready); end
    tick();
    n_checks++;
    if (out_valid !== 1'b0 || out_y !== 4'd0) begin
      n_fail++; $display("FAIL rmid_out: got v=%0d y=%0d expected v=0 y=0", out_valid, out_y);
    end
    reset = 1'b0; in_valid = 4'b0011; in_x = 16'h00FF;
    #1;
    n_checks++;
    if (in_ready !== 4'b0001) begin n_fail++; $display("FAIL rmid_first: got %b expected 0001", in_ready); end
    tick();
    n_checks++;
    if (out_ch !== 2'd0 || out_y !== 4'd3 || out_warm !== 1'b0) begin
      n_fail++; $display("FAIL rmid_after: got ch=%0d y=%0d w=%0d expected ch=0 y=3 w=0", out_ch, out_y, out_warm);
    end
    in_valid = '0;
  endtask

  task automatic test_independence();
    int ey0 [4] = '{3, 7, 11, 15};
    int ey2 [4] = '{1, 2, 3, 4};
    do_reset();
    in_x = {4'd0, 4'd4, 4'd0, 4'd15};
    for (int k = 0; k < 4; k++) begin
      in_valid = 4'b0001;
      tick();
      n_checks++;
      if (out_ch !== 2'd0 || out_y !== 4'(ey0[k])) begin
        n_fail++; $display("FAIL ind_ch0[%0d]: got ch=%0d y=%0d expected ch=0 y=%0d", k, out_ch, out_y, ey0[k]);
      end
      in_valid = 4'b0100;
      tick();
      n_checks++;
      if (out_ch !== 2'd2 || out_y !== 4'(ey2[k])) begin
        n_fail++; $display("FAIL ind_ch2[%0d]: got ch=%0d y=%0d expected ch=2 y=%0d", k, out_ch, out_y, ey2[k]);
      end
    end
    in_valid = '0;
  endtask

  initial begin
    reset = 1'b1; in_valid = '0; in_x = '0; ch_clr = '0; out_ready = 1'b1;
    #1;
    test_reset();
    test_step();
    test_round_robin();
    test_backpressure();
    test_clear();
    test_reset_mid();
    test_independence();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
